// File: rtl/npc_pipe.sv
// Next-PC unit: owns the PC register, picks seq/branch/jump/jump-reg targets and
// parks a redirect that resolves during a fetch stall. Define PC_EXC_EN to add exception entry/return.
module npc_pipe #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int          IMM_W       = 16,
  parameter int          JIDX_W      = 26,
  parameter bit          BR_BASE_PC4 = 1'b0,
  parameter logic [31:0] EXC_VEC     = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        pc_sel,
  input  logic              br_cond,
  input  logic [JIDX_W-1:0] imm,
  input  logic [WIDTH-1:0]  gpr,
`ifdef PC_EXC_EN
  input  logic              exc_req,
  input  logic              eret,
  output logic [WIDTH-1:0]  epc,
`endif
  output logic [WIDTH-1:0]  pc,
  output logic [WIDTH-1:0]  pc_4,
  output logic [WIDTH-1:0]  npc,
  output logic              pend
);

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_JMP = 2'b10,
    SEL_JR  = 2'b11
  } sel_e;

  logic [WIDTH-1:0] pend_tgt;
  logic [WIDTH-1:0] br_base, br_off, br_tgt, jmp_tgt, jr_tgt;
  logic [25:0]      jidx;
  logic             redir;

  assign pc_4    = pc + WIDTH'(4);
  assign br_base = BR_BASE_PC4 ? pc_4 : pc;
  assign br_off  = {{(WIDTH-IMM_W-2){imm[IMM_W-1]}}, imm[IMM_W-1:0], 2'b00};
  assign br_tgt  = br_base + br_off;
  assign jidx    = 26'(imm);
  assign jmp_tgt = {pc_4[WIDTH-1:28], jidx, 2'b00};
  // Register jumps are word aligned regardless of what the GPR holds.
  assign jr_tgt  = gpr & ~WIDTH'(3);

  always_comb begin
    redir = 1'b0;
    npc   = pc_4;
    case (sel_e'(pc_sel))
      SEL_BR:  if (br_cond) begin redir = 1'b1; npc = br_tgt; end
      SEL_JMP: begin redir = 1'b1; npc = jmp_tgt; end
      SEL_JR:  begin redir = 1'b1; npc = jr_tgt; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= WIDTH'(RESET_PC);
      pend     <= 1'b0;
      pend_tgt <= '0;
`ifdef PC_EXC_EN
      epc      <= '0;
    end else if (exc_req) begin
      epc  <= pc;
      pc   <= WIDTH'(EXC_VEC);
      pend <= 1'b0;
    end else if (eret) begin
      pc   <= epc;
      pend <= 1'b0;
`endif
    end else if (stall) begin
      // Only the first redirect seen while stalled is kept.
      if (!pend && redir) begin
        pend     <= 1'b1;
        pend_tgt <= npc;
      end
    end else if (pend) begin
      pc   <= pend_tgt;
      pend <= 1'b0;
    end else begin
      pc <= npc;
    end
  end

endmodule

// File: tb/tb_npc_pipe.sv
// Self-checking bench for npc_pipe (default build): directed cases plus a randomized run
// against a next-PC reference model.
module tb_npc_pipe;
  logic        clk = 1'b0;
  logic        reset, stall, br_cond;
  logic [1:0]  pc_sel;
  logic [25:0] imm;
  logic [31:0] gpr;
  logic [31:0] pc, pc_4, npc;
  logic        pend;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc, m_tgt;
  logic        m_pend;

  npc_pipe dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .br_cond(br_cond),
    .imm(imm), .gpr(gpr), .pc(pc), .pc_4(pc_4), .npc(npc), .pend(pend)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic [1:0] sel,
                                             input logic brc, input logic [25:0] ix,
                                             input logic [31:0] g);
    logic [31:0] off;
    off = {{16{ix[15]}}, ix[15:0]};
    case (sel)
      2'd1:    return brc ? cur + off * 4 : cur + 4;
      2'd2:    return ((cur + 4) & 32'hF000_0000) | ({6'd0, ix} * 4);
      2'd3:    return (g / 4) * 4;
      default: return cur + 4;
    endcase
  endfunction

  function automatic logic is_redir(input logic [1:0] sel, input logic brc);
    return (sel == 2'd1 && brc) || sel[1];
  endfunction

  // Advance the reference model by one edge using current inputs, then clock the DUT.
  task automatic tick();
    if (reset) begin
      m_pc = 32'h3000; m_pend = 1'b0; m_tgt = '0;
    end else if (stall) begin
      if (!m_pend && is_redir(pc_sel, br_cond)) begin
        m_pend = 1'b1; m_tgt = ref_target(m_pc, pc_sel, br_cond, imm, gpr);
      end
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 1'b0;
    end else begin
      m_pc = ref_target(m_pc, pc_sel, br_cond, imm, gpr);
    end
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic s, input logic [1:0] sel, input logic brc,
                        input logic [25:0] ix, input logic [31:0] g);
    stall = s; pc_sel = sel; br_cond = brc; imm = ix; gpr = g;
  endtask

  task automatic do_reset();
    reset = 1'b1; set_in(0, 2'd0, 0, '0, '0); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h3000); end
    checks++; if (pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", pend); end
    checks++; if (pc_4 !== 32'h3004) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", pc_4, 32'h3004); end
    checks++; if (npc !== 32'h3004) begin failures++; $display("FAIL reset_npc got=%h exp=%h", npc, 32'h3004); end
  endtask

  task automatic test_seq();
    logic [31:0] exp [3];
    exp = '{32'h3004, 32'h3008, 32'h300C};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== exp[i]) begin failures++; $display("FAIL seq%0d got=%h exp=%h", i, pc, exp[i]); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(0, 2'd1, 1, 26'h000FFFF, '0); #1;
    checks++; if (npc !== 32'h2FFC) begin failures++; $display("FAIL br_npc got=%h exp=%h", npc, 32'h2FFC); end
    tick();
    checks++; if (pc !== 32'h2FFC) begin failures++; $display("FAIL br_taken got=%h exp=%h", pc, 32'h2FFC); end
    do_reset();
    set_in(0, 2'd1, 0, 26'h000FFFF, '0); tick();
    checks++; if (pc !== 32'h3004) begin failures++; $display("FAIL br_not_taken got=%h exp=%h", pc, 32'h3004); end
    do_reset();
    set_in(0, 2'd3, 0, '0, 32'h3013); tick();
    checks++; if (pc !== 32'h3010) begin failures++; $display("FAIL jr_align got=%h exp=%h", pc, 32'h3010); end
  endtask

  task automatic test_stall_pend();
    do_reset();
    set_in(1, 2'd2, 0, 26'h0000C10, '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 32'h3000 || pend !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d got pc=%h pend=%b exp pc=%h pend=1", i, pc, pend, 32'h3000);
      end
    end
    set_in(0, 2'd0, 0, '0, '0); tick();
    checks++; if (pc !== 32'h3040 || pend !== 1'b0) begin
      failures++; $display("FAIL stall_release got pc=%h pend=%b exp pc=%h pend=0", pc, pend, 32'h3040);
    end
    // Later redirects during the stall and the release-cycle selection are both ignored.
    do_reset();
    set_in(1, 2'd2, 0, 26'h0000C10, '0); tick();
    set_in(1, 2'd3, 0, '0, 32'h5000); tick();
    set_in(0, 2'd3, 0, '0, 32'h7000); tick();
    checks++; if (pc !== 32'h3040) begin failures++; $display("FAIL first_redir_kept got=%h exp=%h", pc, 32'h3040); end
    set_in(0, 2'd0, 0, '0, '0); tick();
    checks++; if (pc !== 32'h3044) begin failures++; $display("FAIL after_release got=%h exp=%h", pc, 32'h3044); end
  endtask

  task automatic test_reset_pend();
    do_reset();
    set_in(1, 2'd3, 0, '0, 32'h8000); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (pc !== 32'h3000 || pend !== 1'b0) begin
      failures++; $display("FAIL reset_clears_pend got pc=%h pend=%b exp pc=%h pend=0", pc, pend, 32'h3000);
    end
    set_in(0, 2'd0, 0, '0, '0); tick();
    checks++; if (pc !== 32'h3004) begin failures++; $display("FAIL post_reset_seq got=%h exp=%h", pc, 32'h3004); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(0, 2'd3, 0, '0, 32'hFFFF_FFFF); tick();
    checks++; if (pc !== 32'hFFFF_FFFC || pc_4 !== 32'h0) begin
      failures++; $display("FAIL wrap_setup got pc=%h pc_4=%h exp pc=%h pc_4=0", pc, pc_4, 32'hFFFF_FFFC);
    end
    set_in(0, 2'd0, 0, '0, '0); tick();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", pc); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_in($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), 1'($urandom),
             26'($urandom), $urandom);
      #1;
      checks++; if (pc !== m_pc || pend !== m_pend || pc_4 !== m_pc + 32'd4 ||
                    npc !== ref_target(m_pc, pc_sel, br_cond, imm, gpr)) begin
        failures++;
        $display("FAIL rand%0d got pc=%h pend=%b npc=%h exp pc=%h pend=%b npc=%h", i, pc, pend, npc,
                 m_pc, m_pend, ref_target(m_pc, pc_sel, br_cond, imm, gpr));
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; set_in(0, 2'd0, 0, '0, '0);
    m_pc = '0; m_pend = 1'b0; m_tgt = '0;
    test_reset();
    test_seq();
    test_branch();
    test_stall_pend();
    test_reset_pend();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
